alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
Multi-cycle operation controller for the calculator's arithmetic datapath. It accepts an operand pair and an opcode (plus/minus/mult/div) from the main keypad FSM with a start/busy/done handshake. It executes the operation by sequencing one shared external add/subtract unit: one pass for plus/minus, 16 iterative passes for shift-add multiply and restoring divide. It returns the result, the remainder and an error flag.

Parameters:
W, 16, operand/result width in bits (unsigned binary)
OP_PLUS, 12, opcode for add
OP_MINUS, 13, opcode for subtract
OP_MULT, 14, opcode for multiply
OP_DIV, 15, opcode for divide

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  request; sampled only in IDLE
op  in  4  opcode
numA  in  W  operand 1 (dividend / multiplicand)
numB  in  W  operand 2 (divisor / multiplier)
addA  out  W+1  shared adder operand A
addB  out  W+1  shared adder operand B
addSub  out  1  0 = A+B, 1 = A-B
addRes  in  W+2  combinational adder result; bit W+1 = borrow (sub, A<B) or 0 (add)
busy  out  1  high from accepted start until DONE exits
done  out  1  one-cycle pulse, result valid
result  out  W  sum/difference/product/quotient, held until next accepted start
remainder  out  W  divide remainder, 0 for other ops
err  out  1  overflow, underflow, divide-by-zero or illegal op; held with result

Behaviour:
- Reset (reset=0, async): state IDLE; busy=0, done=0, result=0, remainder=0, err=0, addA=0, addB=0, addSub=0; internal acc/rem/count cleared. Reset mid-operation aborts the operation with no done pulse.
- Operands and op are latched at the accepting edge E0 (IDLE, start=1). Input changes afterwards are ignored. start while busy is ignored; nothing is queued.
- States: IDLE, ADDSUB, MUL, DIV, DONE. DONE lasts 1 cycle: done=1, busy=1, then IDLE.
- ADDSUB (1 cycle): addA={0,numA}, addB={0,numB}, addSub=(op==OP_MINUS). At E1 result=addRes[W-1:0]. err=addRes[W] for plus; err=addRes[W+1] for minus, with result = numA-numB mod 2^W. done is high in the cycle after E1.
- MUL: 16 cycles (count 0..W-1), MSB-first over numB. addA={acc[W-2:0],1'b0} zero-extended, addB = numB[W-1-count] ? numA : 0, addSub=0. acc<=addRes[W-1:0]. Sticky ovf is set by acc[W-1]=1 before the shift, or by addRes[W]=1. After edge E_W: result=acc (low W bits of the product), err=ovf. done follows.
- DIV: numB==0 goes IDLE->DONE at E0 with result=0, remainder=0, err=1, and done in the cycle after E0. Otherwise restoring division, 16 cycles: addA={rem[W-1:0], dividend bit W-1-count}, addB={0,numB}, addSub=1. If borrow=0: rem<=addRes[W-1:0], qbit=1. Else: rem<=addA[W-1:0], qbit=0. After E_W: result=quotient, remainder=rem, err=0.
- Opcode outside 12..15: behaves like divide-by-zero (err=1, result=0, 1-cycle path).
- In IDLE/DONE, addA/addB/addSub are driven 0.
- Latency from E0 to done high: plus/minus 2 edges; mult/div 17 edges; div0/illegal 1 edge.

Test Plan:
- plus 1234+4321 -> done 2 cycles after start, result=5555, err=0; then 65535+1 -> result=0, err=1.
- minus 5-7 -> result=65534, err=1; 9000-1 -> result=8999, err=0.
- mult 300*200 -> done after 17 edges, result=60000, err=0; 300*300 -> result=24464, err=1.
- div 1000/7 -> result=142, remainder=6, err=0, 17-edge latency; 5/0 -> result=0, err=1, done after 1 edge; op=3 -> same as 5/0.
- start pulsed while busy during mult, and numA changed mid-op -> ignored; result is still from the latched operands; exactly one done pulse.
- reset asserted at cycle 8 of a divide -> all outputs 0 immediately, no done pulse; a new start after release works normally.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle plus/minus/mult/div controller driving one shared external add/subtract unit
// Ports: clk, reset (async, active-low); start/op/numA/numB request, sampled only in IDLE;
//        addA/addB/addSub drive the shared adder, whose result comes back on addRes (bit W+1 = borrow);
//        busy/done handshake; result/remainder/err are held until the next accepted start.
module alu_sequencer #(
  parameter int         W        = 16,
  parameter logic [3:0] OP_PLUS  = 4'd12,
  parameter logic [3:0] OP_MINUS = 4'd13,
  parameter logic [3:0] OP_MULT  = 4'd14,
  parameter logic [3:0] OP_DIV   = 4'd15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [3:0]   op,
  input  logic [W-1:0] numA,
  input  logic [W-1:0] numB,
  output logic [W:0]   addA,
  output logic [W:0]   addB,
  output logic         addSub,
  input  logic [W+1:0] addRes,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic [W-1:0] remainder,
  output logic         err
);
  localparam int CW = $clog2(W);
  typedef enum logic [2:0] {IDLE, ADDSUB, MUL, DIV, DONE} state_t;
  state_t state_q;
  logic [W-1:0] a_q, b_q, acc_q, rem_q, rem_d, quot_d;
  logic [3:0] op_q;
  logic [CW-1:0] cnt_q, idx;
  logic ovf_q, ovf_d, borrow, last;
  // Adder operands are decoded from registered state only, so the adder sees no path from the request inputs.
  always_comb begin
    idx = CW'(W-1) - cnt_q;
    addA = '0;
    addB = '0;
    addSub = 1'b0;
    case (state_q)
      ADDSUB: begin
        addA = {1'b0, a_q};
        addB = {1'b0, b_q};
        addSub = op_q == OP_MINUS;
      end
      MUL: begin
        addA = {1'b0, acc_q[W-2:0], 1'b0};
        addB = b_q[idx] ? {1'b0, a_q} : '0;
      end
      DIV: begin
        addA = {rem_q, a_q[idx]};
        addB = {1'b0, b_q};
        addSub = 1'b1;
      end
      default: ;
    endcase
    borrow = addRes[W+1];
    rem_d = borrow ? addA[W-1:0] : addRes[W-1:0];
    quot_d = {acc_q[W-2:0], ~borrow};
    // acc[W-1] set means the pending doubling already overflows
    ovf_d = ovf_q | acc_q[W-1] | addRes[W];
    last = cnt_q == CW'(W-1);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      acc_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      result <= '0;
      remainder <= '0;
      err <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          a_q <= numA;
          b_q <= numB;
          op_q <= op;
          acc_q <= '0;
          rem_q <= '0;
          cnt_q <= '0;
          ovf_q <= 1'b0;
          busy <= 1'b1;
          if (op == OP_PLUS || op == OP_MINUS) state_q <= ADDSUB;
          else if (op == OP_MULT) state_q <= MUL;
          else if (op == OP_DIV && numB != '0) state_q <= DIV;
          else begin
            state_q <= DONE;
            done <= 1'b1;
            result <= '0;
            remainder <= '0;
            err <= 1'b1;
          end
        end
        ADDSUB: begin
          result <= addRes[W-1:0];
          remainder <= '0;
          err <= op_q == OP_MINUS ? addRes[W+1] : addRes[W];
          done <= 1'b1;
          state_q <= DONE;
        end
        MUL: begin
          acc_q <= addRes[W-1:0];
          ovf_q <= ovf_d;
          cnt_q <= cnt_q + 1'b1;
          if (last) begin
            result <= addRes[W-1:0];
            remainder <= '0;
            err <= ovf_d;
            done <= 1'b1;
            state_q <= DONE;
          end
        end
        DIV: begin
          rem_q <= rem_d;
          acc_q <= quot_d;
          cnt_q <= cnt_q + 1'b1;
          if (last) begin
            result <= quot_d;
            remainder <= rem_d;
            err <= 1'b0;
            done <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: scoreboard bench for alu_sequencer with a behavioural shared adder
module tb_alu_sequencer;
  localparam int W = 16;
  localparam logic [3:0] P = 4'd12, M = 4'd13, X = 4'd14, D = 4'd15;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [3:0] op = '0;
  logic [W-1:0] numA = '0, numB = '0;
  logic [W:0] addA, addB;
  logic addSub, busy, done, err;
  logic [W+1:0] addRes;
  logic [W-1:0] result, remainder;
  typedef struct {
    logic [W-1:0] r;
    logic [W-1:0] rem;
    logic e;
    int cyc;
    string name;
  } exp_t;
  exp_t sb[$];
  int checks = 0, passed = 0, cyc = 0, ndone = 0;
  alu_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .numA(numA), .numB(numB),
    .addA(addA), .addB(addB), .addSub(addSub), .addRes(addRes),
    .busy(busy), .done(done), .result(result), .remainder(remainder), .err(err)
  );
  assign addRes = addSub ? {1'b0, addA} - {1'b0, addB} : {1'b0, addA} + {1'b0, addB};
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset && done) begin
      ndone++;
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_result"}, 32'(result), 32'(e.r));
        chk({e.name, "_remainder"}, 32'(remainder), 32'(e.rem));
        chk({e.name, "_err"}, 32'(err), 32'(e.e));
        chk({e.name, "_latency"}, cyc, e.cyc);
      end
    end
  end
  task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] r, input logic [W-1:0] rm, input logic e,
                       input int lat, input string name);
    exp_t x;
    @(negedge clk);
    op = o;
    numA = a;
    numB = b;
    start = 1'b1;
    x.r = r;
    x.rem = rm;
    x.e = e;
    x.cyc = cyc + lat;
    x.name = name;
    sb.push_back(x);
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_idle"}, 32'(busy), 32'd0);
  endtask
  task automatic run(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] r, input logic [W-1:0] rm, input logic e,
                     input int lat, input string name);
    issue(o, a, b, r, rm, e, lat, name);
    wait_idle(name);
  endtask
  task automatic chk_zero(input string name);
    chk({name, "_busy"}, 32'(busy), 0);
    chk({name, "_done"}, 32'(done), 0);
    chk({name, "_result"}, 32'(result), 0);
    chk({name, "_remainder"}, 32'(remainder), 0);
    chk({name, "_err"}, 32'(err), 0);
    chk({name, "_addA"}, 32'(addA), 0);
    chk({name, "_addB"}, 32'(addB), 0);
    chk({name, "_addSub"}, 32'(addSub), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end
  initial begin
    int nd;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    reset = 1'b1;
    run(P, 16'd1234, 16'd4321, 16'd5555, 16'd0, 1'b0, 2, "plus");
    run(P, 16'd65535, 16'd1, 16'd0, 16'd0, 1'b1, 2, "plus_ovf");
    issue(M, 16'd5, 16'd7, 16'd65534, 16'd0, 1'b1, 2, "minus_under");
    chk("minus_addA", 32'(addA), 32'd5);
    chk("minus_addB", 32'(addB), 32'd7);
    chk("minus_addSub", 32'(addSub), 32'd1);
    wait_idle("minus_under");
    run(M, 16'd9000, 16'd1, 16'd8999, 16'd0, 1'b0, 2, "minus");
    run(X, 16'd300, 16'd200, 16'd60000, 16'd0, 1'b0, 17, "mult");
    run(X, 16'd300, 16'd300, 16'd24464, 16'd0, 1'b1, 17, "mult_ovf");
    run(D, 16'd1000, 16'd7, 16'd142, 16'd6, 1'b0, 17, "div");
    run(D, 16'd5, 16'd0, 16'd0, 16'd0, 1'b1, 1, "div0");
    run(4'd3, 16'd5, 16'd0, 16'd0, 16'd0, 1'b1, 1, "illegal");
    nd = ndone;
    issue(X, 16'd300, 16'd200, 16'd60000, 16'd0, 1'b0, 17, "mult_busy");
    repeat (3) @(negedge clk);
    numA = 16'd999;
    op = P;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("mult_busy");
    repeat (5) @(negedge clk);
    chk("mult_busy_done_count", ndone - nd, 1);
    chk("idle_addA", 32'(addA), 0);
    chk("idle_addB", 32'(addB), 0);
    issue(D, 16'd1000, 16'd7, 16'd142, 16'd6, 1'b0, 17, "div_abort");
    repeat (7) @(negedge clk);
    nd = ndone;
    reset = 1'b0;
    sb.delete();
    #1;
    chk_zero("abort");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort_no_done", ndone - nd, 0);
    run(D, 16'd1000, 16'd7, 16'd142, 16'd6, 1'b0, 17, "div_after_reset");
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
